fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the in-order MIPS pipeline.
- Tracks the destination registers of the last DEPTH in-flight instructions in a bubble-aware shift register.
- For each source operand it produces per-operand forwarding selects, both for ID-stage consumers (branch compare, JR) and for EXE-stage consumers (ALU operands, store data).
- Detects load-use and branch/JR data hazards, raises Stall, inserts bubbles into its own history, and keeps a saturating stall-cycle counter.

Parameters:
- DEPTH, 3: number of older instructions tracked; select value d (1..DEPTH) means "result of the instruction d slots ahead"; 0 means register file.
- REG_W, 5: register-address width.
- NUM_SRC, 3: source operands per instruction (rs, rt, store data).
- EXE_ALU_MIN, 1: minimum distance at which an ALU result is forwardable to an EXE consumer.
- EXE_LOAD_MIN, 2: same, for a load result.
- ID_ALU_MIN, 2: minimum distance at which an ALU result is forwardable to an ID consumer.
- ID_LOAD_MIN, 3: same, for a load result.
- CNT_W, 16: stall counter width.
- Derived: SW = $clog2(DEPTH+1).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- Freeze  in  1  global pipeline hold (memory wait).
- Flush  in  1  squash the instruction in ID.
- ID_Valid  in  1  ID holds a real instruction.
- ID_Src_Reg  in  NUM_SRC*REG_W  source register numbers, operand k at [k*REG_W +: REG_W].
- ID_Src_Use_ID  in  NUM_SRC  operand k is consumed in ID (branch/JR).
- ID_Src_Use_EXE  in  NUM_SRC  operand k is consumed in EXE.
- ID_Reg_Write  in  1  instruction in ID writes a register.
- ID_Dest_Reg  in  REG_W  its destination (link already resolved to 31 by decode).
- ID_Load  in  1  instruction in ID is a load.
- ID_Fwd_Select  out  NUM_SRC*SW  combinational ID-stage selects.
- EXE_Fwd_Select  out  NUM_SRC*SW  registered selects for the instruction now in EXE.
- Stall  out  1  combinational; hold PC and IF/ID, inject bubble into EXE.
- Stall_Cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- History: entries 1..DEPTH, each {valid, dest, load}; entry d is the instruction d slots ahead of ID.
- Reset (asynchronous, RESET=0): all entries invalid, EXE_Fwd_Select=0, Stall_Cycles=0. Stall and ID_Fwd_Select are then 0 because no entry matches.
- Match for operand k: the youngest (smallest d) valid entry with dest == src, src != 0, and a write. Only the youngest match counts; an older match is never used. No match gives select 0.
- ID_Fwd_Select[k] = matched d when ID_Src_Use_ID[k], else 0.
- Hazard on operand k:
  - Use_ID and d < (load ? ID_LOAD_MIN : ID_ALU_MIN), or
  - Use_EXE and d < (load ? EXE_LOAD_MIN : EXE_ALU_MIN).
- Stall = ID_Valid & !Flush & (OR of all operand hazards). Stall is held while the hazard persists.
- Each posedge with Freeze=1: every register holds, and Stall_Cycles does not count.
- Each posedge with Freeze=0:
  - entry[d] <= entry[d-1] for d = 2..DEPTH.
  - entry[1] <= bubble if (Stall | Flush | !ID_Valid); otherwise {ID_Reg_Write & dest != 0, ID_Dest_Reg, ID_Load}.
  - EXE_Fwd_Select[k] <= 0 under the same bubble condition. Otherwise it takes the matched d if Use_EXE[k], else 0.
  - Stall_Cycles increments when Stall=1, and saturates at all-ones.
- Select distance is invariant as producer and consumer advance together. Bubbles occupy distance, so a one-cycle load-use stall turns d=1 into d=2.
- Producers older than DEPTH are assumed written back; reads come from the register file (select 0).
- Freeze and Stall together: Freeze wins; nothing shifts, Stall stays asserted combinationally.
- Flush and a hazard together: Stall=0, and a bubble is inserted.

Decomposition:
- Select encodings (FWD_RF=0) and default MIN constants go in the shared config.v header.
- One sub-module, fwd_match_prio: a per-operand priority matcher. It takes the history vectors and one source, and outputs the matched d, a hit flag and the load flag. It is instantiated NUM_SRC times via generate.

Test Plan:
- Defaults. `add r3` then `sub r5,r3,r4` (EXE use): no Stall; the next cycle EXE_Fwd_Select[rs]=1.
- `lw r3` then `add r5,r3,r3`: Stall=1 for exactly one cycle, Stall_Cycles=1. Then EXE_Fwd_Select rs=2 and rt=2.
- `add r3`, `nop`, `beq r3,r0`: at ID, d=2 meets ID_ALU_MIN, so no stall and ID_Fwd_Select[rs]=2. With no nop: one stall cycle, then ID select 2.
- `add r3`, `add r3`, then a reader of r3: select=1 (youngest). Writes to r0 never match, select=0.
- Freeze held 4 cycles during a load-use stall: history and EXE selects unchanged, counter unchanged. Stall asserts during Freeze; after release, behaviour is identical to the unfrozen case.
- RESET low mid-stall: all outputs 0 immediately (async), history cleared. After release, an r3 reader gets select 0.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg
//   Shared configuration for the forwarding/hazard unit: default parameter
//   values, the register-file select encoding, and a helper that picks the
//   minimum forwarding distance for a producer kind.
//   No ports (package).
package fwd_hazard_unit_pkg;

  localparam int DEF_DEPTH        = 3;
  localparam int DEF_REG_W        = 5;
  localparam int DEF_NUM_SRC      = 3;
  localparam int DEF_EXE_ALU_MIN  = 1;
  localparam int DEF_EXE_LOAD_MIN = 2;
  localparam int DEF_ID_ALU_MIN   = 2;
  localparam int DEF_ID_LOAD_MIN  = 3;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_SW           = $clog2(DEF_DEPTH + 1);

  // Select value meaning "read the register file" (no forwarding).
  localparam int FWD_RF = 0;

  // Minimum distance at which a producer's result can reach a consumer.
  function automatic int min_dist(input logic is_load, input int alu_min, input int load_min);
    return is_load ? load_min : alu_min;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if
//   Bundles the ID-stage decode information flowing into the hazard unit and
//   the forwarding selects / stall information flowing back to the pipeline.
//   master: pipeline side (drives decode info, reads selects/stall).
//   slave : hazard unit side.
//   Signals: Freeze, Flush, ID_Valid, ID_Src_Reg, ID_Src_Use_ID,
//            ID_Src_Use_EXE, ID_Reg_Write, ID_Dest_Reg, ID_Load (to unit);
//            ID_Fwd_Select, EXE_Fwd_Select, Stall, Stall_Cycles (from unit).
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int REG_W   = DEF_REG_W,
  parameter int SW      = DEF_SW,
  parameter int CNT_W   = DEF_CNT_W
);
  logic                     Freeze;
  logic                     Flush;
  logic                     ID_Valid;
  logic [NUM_SRC*REG_W-1:0] ID_Src_Reg;
  logic [NUM_SRC-1:0]       ID_Src_Use_ID;
  logic [NUM_SRC-1:0]       ID_Src_Use_EXE;
  logic                     ID_Reg_Write;
  logic [REG_W-1:0]         ID_Dest_Reg;
  logic                     ID_Load;
  logic [NUM_SRC*SW-1:0]    ID_Fwd_Select;
  logic [NUM_SRC*SW-1:0]    EXE_Fwd_Select;
  logic                     Stall;
  logic [CNT_W-1:0]         Stall_Cycles;

  modport master (
    output Freeze, Flush, ID_Valid, ID_Src_Reg, ID_Src_Use_ID, ID_Src_Use_EXE,
           ID_Reg_Write, ID_Dest_Reg, ID_Load,
    input  ID_Fwd_Select, EXE_Fwd_Select, Stall, Stall_Cycles
  );

  modport slave (
    input  Freeze, Flush, ID_Valid, ID_Src_Reg, ID_Src_Use_ID, ID_Src_Use_EXE,
           ID_Reg_Write, ID_Dest_Reg, ID_Load,
    output ID_Fwd_Select, EXE_Fwd_Select, Stall, Stall_Cycles
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_match_prio.sv
// fwd_match_prio
//   Priority matcher for one source operand against the in-flight history.
//   Ports:
//     hist_valid [DEPTH] : entry d valid (bit d-1), already gated by write & dest!=0
//     hist_dest  [DEPTH*REG_W] : destination of entry d at [(d-1)*REG_W +: REG_W]
//     hist_load  [DEPTH] : entry d is a load
//     src        : source register number
//     sel        : distance d of the youngest matching entry, FWD_RF if none
//     hit        : a match was found
//     load       : the matched producer is a load
module fwd_match_prio
  import fwd_hazard_unit_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int REG_W = DEF_REG_W,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]       hist_valid,
  input  logic [DEPTH*REG_W-1:0] hist_dest,
  input  logic [DEPTH-1:0]       hist_load,
  input  logic [REG_W-1:0]       src,
  output logic [SW-1:0]          sel,
  output logic                   hit,
  output logic                   load
);

  // Scan from oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    sel  = SW'(FWD_RF);
    hit  = 1'b0;
    load = 1'b0;
    for (int d = DEPTH; d >= 1; d--) begin
      if (src != '0 && hist_valid[d-1] && hist_dest[(d-1)*REG_W +: REG_W] == src) begin
        sel  = SW'(d);
        hit  = 1'b1;
        load = hist_load[d-1];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and hazard unit for the in-order pipeline. Keeps a shift
//   register of the last DEPTH in-flight destinations (bubbles included),
//   computes per-operand forwarding selects for ID and EXE consumers, raises
//   Stall on load-use and branch/JR hazards, and counts stall cycles.
//   Ports:
//     CLK   : clock
//     RESET : asynchronous active-low reset
//     bus   : fwd_hazard_unit_if.slave (decode info in, selects/stall out)
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int REG_W        = DEF_REG_W,
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int EXE_ALU_MIN  = DEF_EXE_ALU_MIN,
  parameter int EXE_LOAD_MIN = DEF_EXE_LOAD_MIN,
  parameter int ID_ALU_MIN   = DEF_ID_ALU_MIN,
  parameter int ID_LOAD_MIN  = DEF_ID_LOAD_MIN,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RESET,
  fwd_hazard_unit_if.slave bus
);

  localparam int SW = $clog2(DEPTH + 1);

  // History: bit/slice d-1 holds the instruction d slots ahead of ID.
  logic [DEPTH-1:0]       valid_reg;
  logic [DEPTH-1:0]       load_reg;
  logic [DEPTH*REG_W-1:0] dest_reg;

  logic [NUM_SRC*SW-1:0]  exe_sel_reg;
  logic [NUM_SRC*SW-1:0]  exe_sel_next;
  logic [NUM_SRC*SW-1:0]  id_sel;
  logic [NUM_SRC-1:0]     hazard;
  logic [CNT_W-1:0]       cnt_reg;

  logic stall;
  logic bubble;
  logic new_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [SW-1:0] m_sel;
      logic          m_hit;
      logic          m_load;

      fwd_match_prio #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .SW    (SW)
      ) u_match (
        .hist_valid (valid_reg),
        .hist_dest  (dest_reg),
        .hist_load  (load_reg),
        .src        (bus.ID_Src_Reg[gi*REG_W +: REG_W]),
        .sel        (m_sel),
        .hit        (m_hit),
        .load       (m_load)
      );

      assign id_sel[gi*SW +: SW] = bus.ID_Src_Use_ID[gi] ? m_sel : SW'(FWD_RF);

      // A producer closer than the minimum distance cannot have its result
      // ready when this consumer needs it.
      assign hazard[gi] = m_hit &
        ((bus.ID_Src_Use_ID[gi]  & (int'(m_sel) < min_dist(m_load, ID_ALU_MIN,  ID_LOAD_MIN))) |
         (bus.ID_Src_Use_EXE[gi] & (int'(m_sel) < min_dist(m_load, EXE_ALU_MIN, EXE_LOAD_MIN))));

      // Distance is unchanged as producer and consumer advance together, so
      // the ID-time match is exactly the select needed once in EXE.
      assign exe_sel_next[gi*SW +: SW] =
        (bubble || !bus.ID_Src_Use_EXE[gi]) ? SW'(FWD_RF) : m_sel;
    end
  endgenerate

  assign stall     = bus.ID_Valid & ~bus.Flush & (|hazard);
  assign bubble    = stall | bus.Flush | ~bus.ID_Valid;
  assign new_valid = bus.ID_Reg_Write & (bus.ID_Dest_Reg != '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_reg   <= '0;
      load_reg    <= '0;
      dest_reg    <= '0;
      exe_sel_reg <= '0;
      cnt_reg     <= '0;
    end else if (!bus.Freeze) begin
      valid_reg   <= (valid_reg << 1) | DEPTH'(~bubble & new_valid);
      load_reg    <= (load_reg << 1)  | DEPTH'(~bubble & bus.ID_Load);
      dest_reg    <= (dest_reg << REG_W) |
                     (DEPTH*REG_W)'(bubble ? '0 : bus.ID_Dest_Reg);
      exe_sel_reg <= exe_sel_next;
      if (stall && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.ID_Fwd_Select  = id_sel;
  assign bus.EXE_Fwd_Select = exe_sel_reg;
  assign bus.Stall          = stall;
  assign bus.Stall_Cycles   = cnt_reg;

endmodule
